hub75_bcm_scanner: RTL and testbench
====================================

Name: hub75_bcm_scanner

Overview:
- Next-generation HUB75 row-scan / binary-coded-modulation (BCM) sequencer for chained LED matrix panels.
- Orders bit-plane loads and sequences latch, blanking and output-enable.
- Drives the row mux and handshakes with the column shift-register block, which owns the pixel data path.
- New relative to the current driver: shift of the next plane overlaps display of the current one; adds global brightness, programmable blanking dead time, progressive/interleaved scan, and a chained-panel count.

Parameters:
- COLS, 64, columns per panel
- PANELS, 1, panels chained on one data chain; base time BASE = COLS*PANELS cycles
- ROWS, 32, panel rows; SCAN = ROWS/2 scan lines (two rows driven per line)
- BCM_BITS, 8, bit planes per colour
- BLANK_CYCLES, 4, oe_n-high dead time around each address/latch change (>=1)
- BRIGHT_W, 8, brightness input width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  scan enable
- interleave  in  1  0 = progressive line order, 1 = evens then odds
- brightness  in  BRIGHT_W  global duty
- sr_start  out  1  one-cycle pulse: shift-register block begins loading sr_row/sr_bit
- sr_row  out  clog2(SCAN)  line being loaded
- sr_bit  out  clog2(BCM_BITS)  plane being loaded
- sr_done  in  1  one-cycle pulse: load complete
- latch  out  1  panel latch strobe
- oe_n  out  1  panel output enable, active-low
- row_addr  out  clog2(SCAN)  displayed line (A..E)
- frame_done  out  1  one-cycle pulse after last plane of last line

Behaviour:
- Reset or enable=0 → state IDLE and outputs held:
  - oe_n=1; sr_start, latch and frame_done = 0; row_addr, sr_row and sr_bit = 0.
  - Any pending sr_done flag cleared.
  - Takes effect the next cycle, including mid-DISPLAY or mid-LOAD.
- Slot order: (line, bit) with bit 0..BCM_BITS-1 inner and line outer.
  - Progressive line sequence: 0,1,…,SCAN-1.
  - Interleaved line sequence: 0,2,…, then 1,3,….
  - After the last slot, frame_done=1 for one cycle and the order wraps.
  - interleave and brightness are sampled only at frame start; mid-frame changes are ignored.
- States:
  - IDLE: on enable=1, pulse sr_start for slot 0 and go to PRELOAD.
  - PRELOAD: wait for sr_done, then go to BLANK.
  - BLANK: oe_n=1 for BLANK_CYCLES cycles. row_addr takes the loaded slot's line in the first BLANK cycle. Then go to LATCH.
  - LATCH: latch=1 for exactly one cycle with oe_n=1, then go to DISPLAY.
  - DISPLAY:
    - In the first cycle, pulse sr_start with sr_row/sr_bit set to the next slot.
    - Counter runs T = BASE<<bit cycles.
    - oe_n=0 for the first ON = (T*(brightness+1))>>BRIGHT_W cycles, then oe_n=1. All-ones brightness gives ON=T; ON may be 0.
    - Exit to BLANK when count>=T AND the sticky done flag is set.
    - A late sr_done stretches DISPLAY with oe_n held at 1 (stall).
- Handshake rules:
  - sr_done is accepted only from the cycle after sr_start.
  - sr_done arriving while no load is outstanding is ignored.
  - sr_done in the same cycle the counter reaches T is accepted.
- Widths:
  - Display counter is clog2(BASE<<(BCM_BITS-1))+1 bits; no overflow at max T.
  - ON product is computed at counter width + BRIGHT_W.
- sr_row/sr_bit are stable from sr_start until sr_done.

Optional Feature:
- Macro: LED_DRV_STALL_STATS_EN.
- Defined:
  - Adds output stall_cycles [15:0]: count of DISPLAY cycles spent past T waiting on sr_done during the previous frame.
  - Updated in the cycle frame_done pulses; saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. rst=1 mid-DISPLAY with oe_n=0 → next cycle: oe_n=1, latch=0, row_addr=0, IDLE; enable holds, then restart at slot 0.
2. COLS=4, PANELS=1, BCM_BITS=3, brightness=8'hFF, sr_done 2 cycles after each sr_start → oe_n low for exactly 4, 8, 16 cycles per line; latch 1 cycle, preceded by 4 oe_n-high cycles.
3. Same config, brightness=8'h7F → ON = 2, 4, 8 cycles; DISPLAY lengths unchanged.
4. ROWS=8, interleave=1 → row_addr sequence 0,2,1,3 (each for 3 planes); frame_done once per 12 slots; toggling interleave mid-frame has no effect until the next frame.
5. sr_done delayed 10 cycles past T on bit 2 → DISPLAY extends 10 cycles with oe_n=1; with LED_DRV_STALL_STATS_EN, stall_cycles=10 after frame_done.
6. enable dropped during PRELOAD, sr_done arrives afterward → ignored; on re-enable, a fresh sr_start for slot 0 is issued.

Source files
------------

// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner
//   HUB75 row-scan / binary-coded-modulation sequencer. Walks (line, bit)
//   slots, handshakes plane loads with the column shift-register block,
//   and sequences blanking, latch and output-enable. The next plane's shift
//   overlaps display of the current one.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            scan enable (0 forces IDLE)
//   interleave        0 progressive, 1 evens then odds (sampled per frame)
//   brightness        global duty (sampled per frame)
//   sr_start/sr_row/sr_bit/sr_done   shift-register load handshake
//   latch, oe_n, row_addr            panel controls
//   frame_done        one-cycle pulse after last slot of a frame
//   stall_cycles      (LED_DRV_STALL_STATS_EN only) per-frame stall count
//
// Optional feature macro: LED_DRV_STALL_STATS_EN
module hub75_bcm_scanner #(
    parameter int COLS         = 64,
    parameter int PANELS       = 1,
    parameter int ROWS         = 32,
    parameter int BCM_BITS     = 8,
    parameter int BLANK_CYCLES = 4,
    parameter int BRIGHT_W     = 8,
    localparam int SCAN = ROWS / 2,
    localparam int LW   = (SCAN > 1) ? $clog2(SCAN) : 1,
    localparam int BW   = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                interleave,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                sr_start,
    output logic [LW-1:0]       sr_row,
    output logic [BW-1:0]       sr_bit,
    input  logic                sr_done,
    output logic                latch,
    output logic                oe_n,
    output logic [LW-1:0]       row_addr,
    output logic                frame_done
`ifdef LED_DRV_STALL_STATS_EN
    ,
    output logic [15:0]         stall_cycles
`endif
);

    localparam int BASE = COLS * PANELS;
    localparam int CW   = $clog2(BASE << (BCM_BITS - 1)) + 1;
    localparam int PW   = CW + BRIGHT_W;
    localparam int BCW  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int HALF = (SCAN + 1) / 2;

    typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_BLANK, S_LATCH, S_DISPLAY} state_t;

    state_t              r_state;
    logic                r_sr_start, r_latch, r_oe_n, r_frame_done;
    logic [LW-1:0]       r_sr_row, r_row_addr, r_ld_pos;
    logic [BW-1:0]       r_sr_bit, r_dsp_bit;
    logic                r_pending, r_done_flag, r_dsp_last, r_ilv;
    logic [BRIGHT_W-1:0] r_bright;
    logic [BCW-1:0]      r_bcnt;
    logic [CW-1:0]       r_cnt, r_t, r_on;

    // Scan position -> physical line for the chosen order.
    function automatic logic [LW-1:0] f_line(input logic [LW-1:0] pos, input logic ilv);
        if (!ilv)
            return pos;
        if (int'(pos) < HALF)
            return LW'(2 * int'(pos));
        return LW'(2 * (int'(pos) - HALF) + 1);
    endfunction

    logic          w_accept, w_done, w_last_ld, w_disp_end, w_exit;
    logic [CW-1:0] w_t, w_on, w_cnt_nxt;
    logic [PW-1:0] w_prod;
    logic [LW-1:0] w_npos;
    logic [BW-1:0] w_nbit;

    // A done pulse counts only for an outstanding load, and never in the
    // same cycle as the sr_start that opened it.
    assign w_accept   = r_pending && !r_sr_start && sr_done;
    assign w_done     = r_done_flag || w_accept;
    assign w_last_ld  = (r_ld_pos == LW'(SCAN - 1)) && (r_sr_bit == BW'(BCM_BITS - 1));
    assign w_t        = CW'(BASE) << r_dsp_bit;
    assign w_prod     = PW'(w_t) * (PW'(r_bright) + PW'(1));
    assign w_on       = w_prod[PW-1:BRIGHT_W];
    assign w_cnt_nxt  = (r_cnt < r_t) ? r_cnt + CW'(1) : r_cnt;
    assign w_disp_end = (r_cnt + CW'(1)) >= r_t;
    assign w_exit     = (r_state == S_DISPLAY) && w_disp_end && w_done;

    always_comb begin
        w_nbit = r_sr_bit + BW'(1);
        w_npos = r_ld_pos;
        if (r_sr_bit == BW'(BCM_BITS - 1)) begin
            w_nbit = '0;
            w_npos = (r_ld_pos == LW'(SCAN - 1)) ? '0 : r_ld_pos + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        r_sr_start   <= 1'b0;
        r_latch      <= 1'b0;
        r_frame_done <= 1'b0;
        if (rst || !enable) begin
            r_state     <= S_IDLE;
            r_oe_n      <= 1'b1;
            r_row_addr  <= '0;
            r_sr_row    <= '0;
            r_sr_bit    <= '0;
            r_ld_pos    <= '0;
            r_pending   <= 1'b0;
            r_done_flag <= 1'b0;
            r_dsp_bit   <= '0;
            r_dsp_last  <= 1'b0;
            r_bcnt      <= '0;
            r_cnt       <= '0;
            r_t         <= '0;
            r_on        <= '0;
            r_ilv       <= 1'b0;
            r_bright    <= '0;
        end else begin
            if (w_accept) begin
                r_pending   <= 1'b0;
                r_done_flag <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_sr_start <= 1'b1;
                    r_sr_row   <= '0;
                    r_sr_bit   <= '0;
                    r_ld_pos   <= '0;
                    r_pending  <= 1'b1;
                    r_ilv      <= interleave;
                    r_bright   <= brightness;
                    r_state    <= S_PRELOAD;
                end
                S_PRELOAD: begin
                    if (w_done) begin
                        r_state     <= S_BLANK;
                        r_bcnt      <= '0;
                        r_oe_n      <= 1'b1;
                        r_row_addr  <= r_sr_row;
                        r_dsp_bit   <= r_sr_bit;
                        r_dsp_last  <= w_last_ld;
                        r_done_flag <= 1'b0;
                    end
                end
                S_BLANK: begin
                    r_oe_n <= 1'b1;
                    if (r_bcnt == BCW'(BLANK_CYCLES - 1)) begin
                        r_state <= S_LATCH;
                        r_latch <= 1'b1;
                        r_t     <= w_t;
                        r_on    <= w_on;
                    end else begin
                        r_bcnt <= r_bcnt + BCW'(1);
                    end
                end
                S_LATCH: begin
                    // Kick off the next plane's load as display begins; a
                    // wrap to slot 0 is the frame boundary for sampling.
                    r_state    <= S_DISPLAY;
                    r_cnt      <= '0;
                    r_oe_n     <= (r_on == '0);
                    r_sr_start <= 1'b1;
                    r_sr_row   <= f_line(w_npos, r_ilv);
                    r_sr_bit   <= w_nbit;
                    r_ld_pos   <= w_npos;
                    r_pending  <= 1'b1;
                    if (w_last_ld) begin
                        r_ilv    <= interleave;
                        r_bright <= brightness;
                    end
                end
                S_DISPLAY: begin
                    if (w_exit) begin
                        r_state      <= S_BLANK;
                        r_bcnt       <= '0;
                        r_oe_n       <= 1'b1;
                        r_row_addr   <= r_sr_row;
                        r_dsp_bit    <= r_sr_bit;
                        r_dsp_last   <= w_last_ld;
                        r_done_flag  <= 1'b0;
                        r_frame_done <= r_dsp_last;
                    end else begin
                        // Counter parks at T while stalled, forcing oe_n high.
                        r_cnt  <= w_cnt_nxt;
                        r_oe_n <= (w_cnt_nxt >= r_on);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LED_DRV_STALL_STATS_EN
    logic [15:0] r_stall_acc, r_stall_out;
    logic        w_stall;
    logic [15:0] w_stall_sum;

    assign w_stall     = (r_state == S_DISPLAY) && (r_cnt == r_t);
    assign w_stall_sum = (w_stall && r_stall_acc != 16'hFFFF) ? r_stall_acc + 16'd1 : r_stall_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_acc <= '0;
            r_stall_out <= '0;
        end else if (!enable) begin
            r_stall_acc <= '0;
        end else if (w_exit && r_dsp_last) begin
            r_stall_out <= w_stall_sum;
            r_stall_acc <= '0;
        end else begin
            r_stall_acc <= w_stall_sum;
        end
    end

    assign stall_cycles = r_stall_out;
`endif

    assign sr_start   = r_sr_start;
    assign sr_row     = r_sr_row;
    assign sr_bit     = r_sr_bit;
    assign latch      = r_latch;
    assign oe_n       = r_oe_n;
    assign row_addr   = r_row_addr;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb_hub75_bcm_scanner
//   Self-checking bench for hub75_bcm_scanner (COLS=4, ROWS=8, BCM_BITS=3).
//   A shift-register responder answers each sr_start after a chosen delay;
//   a slot-level model predicts line order, ON time, slot length,
//   frame_done placement and stall totals.
module tb_hub75_bcm_scanner;

    localparam int COLS = 4, PANELS = 1, ROWS = 8, BITS = 3, BLANK = 4, BRW = 8;
    localparam int SCAN  = ROWS / 2;
    localparam int BASE  = COLS * PANELS;
    localparam int SLOTS = SCAN * BITS;

    logic           clk = 1'b0;
    logic           rst, enable, interleave;
    logic [BRW-1:0] brightness;
    logic           sr_start, sr_done, latch, oe_n, frame_done;
    logic [1:0]     sr_row, row_addr;
    logic [1:0]     sr_bit;
`ifdef LED_DRV_STALL_STATS_EN
    logic [15:0]    stall_cycles;
`endif

    hub75_bcm_scanner #(
        .COLS(COLS), .PANELS(PANELS), .ROWS(ROWS), .BCM_BITS(BITS),
        .BLANK_CYCLES(BLANK), .BRIGHT_W(BRW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .interleave(interleave),
        .brightness(brightness), .sr_start(sr_start), .sr_row(sr_row),
        .sr_bit(sr_bit), .sr_done(sr_done), .latch(latch), .oe_n(oe_n),
        .row_addr(row_addr), .frame_done(frame_done)
`ifdef LED_DRV_STALL_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit dead  = 0;
    int resp_dly = 2;
    int cd = 0;

    // model state
    int s = 0;
    bit cur_ilv = 0;
    int cur_bri = 255;
    int fstall = 0;

    // responder: sr_done 'resp_dly' cycles after the sr_start cycle
    initial begin
        sr_done = 1'b0;
        forever begin
            @(negedge clk);
            sr_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) sr_done = 1'b1;
            end
            if (sr_start === 1'b1) cd = resp_dly;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=event", tag);
        dead = 1;
    endtask

    function automatic int mline(input int pos, input bit ilv);
        if (!ilv) return pos;
        return (pos < SCAN / 2) ? 2 * pos : 2 * (pos - SCAN / 2) + 1;
    endfunction

    // From sr_start of slot 0 to its latch; leaves us at the latch cycle.
    task automatic start_frame(input int d);
        int n;
        if (dead) return;
        resp_dly = d;
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n > 50) begin timeout("wait_sr_start"); return; end
        end while (sr_start !== 1'b1);
        chk("start_row", sr_row, 0);
        chk("start_bit", sr_bit, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n > 200) begin timeout("wait_first_latch"); return; end
        end while (latch !== 1'b1);
        chk("preload_len", n, d + BLANK + 1);
        s = 0;
        cur_ilv = interleave;
        cur_bri = int'(brightness);
        fstall = 0;
    endtask

    // Entered at the negedge of slot s's latch cycle; exits at the next latch.
    task automatic run_slot(input int dly);
        int pos, bt, t, on, d, ns, nline, nbit;
        int n, lows, gap, fds, starts, start_n, srow, sbit;
        if (dead) return;
        pos = s / BITS;
        bt  = s % BITS;
        t   = BASE << bt;
        on  = (t * (cur_bri + 1)) >> BRW;
        d   = (dly + 1 > t) ? dly + 1 : t;
        resp_dly = dly;
        chk("row_addr", row_addr, mline(pos, cur_ilv));
        chk("latch_oe_n", oe_n, 1);
        ns    = (s + 1) % SLOTS;
        nline = (ns == 0) ? 0 : mline(ns / BITS, cur_ilv);
        nbit  = ns % BITS;
        n = 0; lows = 0; gap = 0; fds = 0; starts = 0; start_n = -1; srow = -1; sbit = -1;
        while (1) begin
            @(negedge clk);
            n++;
            if (latch === 1'b1) break;
            if (oe_n === 1'b0) begin
                lows++;
                if (lows != n) gap = 1;
            end
            if (frame_done === 1'b1) fds++;
            if (sr_start === 1'b1) begin
                starts++;
                if (start_n < 0) begin start_n = n; srow = int'(sr_row); sbit = int'(sr_bit); end
            end
            if (n > 4000) begin timeout("wait_latch"); return; end
        end
        chk("on_cycles", lows, on);
        chk("on_contig", gap, 0);
        chk("slot_len", n, d + BLANK + 1);
        chk("sr_starts", starts, 1);
        chk("start_at", start_n, 1);
        chk("next_row", srow, nline);
        chk("next_bit", sbit, nbit);
        chk("frame_done", fds, (s == SLOTS - 1) ? 1 : 0);
        fstall += d - t;
        if (s == SLOTS - 1) begin
`ifdef LED_DRV_STALL_STATS_EN
            chk("stall_cycles", stall_cycles, (fstall > 65535) ? 65535 : fstall);
`endif
            fstall = 0;
        end
        s = ns;
        if (ns == 0) begin
            cur_ilv = interleave;
            cur_bri = int'(brightness);
        end
    endtask

    task automatic run_frame(input int dly, input int stall_slot, input int stall_dly,
                             input bit rnd, input bit new_ilv, input int new_bri);
        int d;
        for (int i = 0; i < SLOTS; i++) begin
            if (i == 6) begin
                interleave = new_ilv;
                brightness = BRW'(new_bri);
            end
            if (rnd) d = $urandom_range(1, 20);
            else     d = (i == stall_slot) ? stall_dly : dly;
            run_slot(d);
        end
    endtask

    initial begin
        int viol;
        rst = 1'b1; enable = 1'b0; interleave = 1'b0; brightness = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_latch", latch, 0);
        chk("rst_sr_start", sr_start, 0);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_sr_row", sr_row, 0);
        chk("rst_sr_bit", sr_bit, 0);
        chk("rst_frame_done", frame_done, 0);
`ifdef LED_DRV_STALL_STATS_EN
        chk("rst_stall", stall_cycles, 0);
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_sr_start", sr_start, 0);

        // enable dropped during PRELOAD; the late sr_done must be ignored
        resp_dly = 8;
        enable = 1'b1;
        viol = 0;
        do begin @(negedge clk); viol++; end while (sr_start !== 1'b1 && viol < 20);
        chk("pre_sr_start", sr_start, 1);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        viol = 0;
        repeat (12) begin
            @(negedge clk);
            if (sr_start !== 1'b0 || latch !== 1'b0 || oe_n !== 1'b1) viol++;
        end
        chk("idle_quiet", viol, 0);
        start_frame(3);

        run_frame(2, -1, 0, 0, 1'b1, 255);              // progressive, full brightness
        run_frame(2, 2, 25, 0, 1'b0, 127);              // interleaved, 10-cycle stall
        run_frame(2, -1, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 255)); // half brightness
        run_frame(0, -1, 0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 255));
        run_frame(0, -1, 0, 1, 1'($urandom_range(0, 1)), 255);

        // reset mid-DISPLAY with oe_n low
        for (int i = 0; i < 4; i++) run_slot(2);
        if (!dead) begin
            chk("slot4_row", row_addr, mline(1, cur_ilv));
            resp_dly = 2;
            repeat (2) @(negedge clk);
            chk("disp_oe_low", oe_n, 0);
            rst = 1'b1;
            @(negedge clk);
            chk("mid_rst_oe_n", oe_n, 1);
            chk("mid_rst_latch", latch, 0);
            chk("mid_rst_row", row_addr, 0);
            chk("mid_rst_sr_start", sr_start, 0);
            chk("mid_rst_sr_row", sr_row, 0);
            chk("mid_rst_sr_bit", sr_bit, 0);
            repeat (30) @(negedge clk);
`ifdef LED_DRV_STALL_STATS_EN
            chk("mid_rst_stall", stall_cycles, 0);
`endif
            chk("hold_oe_n", oe_n, 1);
            rst = 1'b0;
            start_frame(3);
            run_frame(2, -1, 0, 0, 1'b0, 255);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
